// File: rtl/mem_access_pkg.sv
// mem_access_pkg: MIPS load/store opcodes, FSM states and lane helpers
package mem_access_pkg;
    typedef enum logic [5:0] {
        OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LWL = 6'h22, OP_LW = 6'h23, OP_LBU = 6'h24,
        OP_LHU = 6'h25, OP_LWR = 6'h26, OP_SB  = 6'h28, OP_SH = 6'h29, OP_SW  = 6'h2b
    } op_e;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
    function automatic logic is_byte(input logic [5:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_SB;
    endfunction
    function automatic logic is_half(input logic [5:0] op);
        return op == OP_LH || op == OP_LHU || op == OP_SH;
    endfunction
    function automatic logic is_load(input logic [5:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LWL || op == OP_LW ||
               op == OP_LBU || op == OP_LHU || op == OP_LWR;
    endfunction
    function automatic logic is_store(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction
    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] b);
        return is_half(op) ? b[0] : (op == OP_LW || op == OP_SW) ? (b != 2'b00) : 1'b0;
    endfunction
    function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] b);
        return is_byte(op) ? 4'b0001 << b : is_half(op) ? (b[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: extracts/extends the addressed lane or merges LWL/LWR into rt_old
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [31:0] rt_old_i,
    input  logic [5:0]  op_i,
    input  logic [1:0]  b_i,
    output logic [31:0] data_o
);
    logic [31:0] rs;
    logic [15:0] h;
    logic [4:0]  lsh, rsh;
    always_comb begin
        rsh = {b_i, 3'b000};
        lsh = {2'd3 - b_i, 3'b000};
        rs = r_i >> rsh;
        h = b_i[1] ? r_i[31:16] : r_i[15:0];
        data_o = op_i == OP_LB  ? {{24{rs[7]}}, rs[7:0]} :
                 op_i == OP_LBU ? {24'b0, rs[7:0]} :
                 op_i == OP_LH  ? {{16{h[15]}}, h} :
                 op_i == OP_LHU ? {16'b0, h} :
                 op_i == OP_LW  ? r_i :
                 op_i == OP_LWL ? (r_i << lsh) | (rt_old_i & ~(32'hFFFF_FFFF << lsh)) :
                 op_i == OP_LWR ? rs | (rt_old_i & ~(32'hFFFF_FFFF >> rsh)) : 32'b0;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time fetch/load/store engine onto an Avalon-style bus
// with alignment checking, optional waitrequest watchdog and load data alignment.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int ALIGN_CHECK    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_fetch,
    input  logic [31:0]       pc,
    input  logic [31:0]       alu_addr,
    input  logic [5:0]        opcode,
    input  logic [31:0]       store_data,
    input  logic [31:0]       rt_old,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              addr_err,
    output logic              bus_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    input  logic [31:0]       readdata
);
    state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d, rt_q, rt_d, wd_q, wd_d, data_q, data_d, acc_addr, la_out;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0] op_q, op_d, acc_op;
    logic [3:0] be_q, be_d;
    logic [1:0] b_q, b_d;
    logic rd_q, rd_d, wr_q, wr_d, rv_q, rv_d, ae_q, ae_d, be_err_q, be_err_d, bad, timeout;
    load_align u_align (.r_i(readdata), .rt_old_i(rt_q), .op_i(op_q), .b_i(b_q), .data_o(la_out));
    always_comb begin
        // a fetch is treated as an LW for alignment, lanes and result
        acc_addr = req_fetch ? pc : alu_addr;
        acc_op = req_fetch ? OP_LW : opcode;
        bad = ALIGN_CHECK != 0 && misaligned(acc_op, acc_addr[1:0]);
        timeout = TIMEOUT_CYCLES != 0 && waitrequest && cnt_q == 32'(TIMEOUT_CYCLES - 1);
        state_d = state_q;
        cnt_d = cnt_q;
        rt_d = rt_q;
        wd_d = wd_q;
        data_d = data_q;
        addr_d = addr_q;
        op_d = op_q;
        be_d = be_q;
        b_d = b_q;
        rd_d = rd_q;
        wr_d = wr_q;
        rv_d = 1'b0;
        ae_d = ae_q;
        be_err_d = be_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d = acc_op;
                b_d = acc_addr[1:0];
                rt_d = rt_old;
                addr_d = {acc_addr[ADDR_W-1:2], 2'b00};
                be_d = lane_be(acc_op, acc_addr[1:0]);
                wd_d = acc_op == OP_SB ? {4{store_data[7:0]}} :
                       acc_op == OP_SH ? {2{store_data[15:0]}} : store_data;
                cnt_d = '0;
                data_d = '0;
                ae_d = bad;
                be_err_d = 1'b0;
                if (bad || !(is_load(acc_op) || is_store(acc_op))) begin
                    state_d = RESP;
                    rv_d = 1'b1;
                end else begin
                    state_d = BUS;
                    rd_d = is_load(acc_op);
                    wr_d = is_store(acc_op);
                end
            end
            BUS: if (!waitrequest || timeout) begin
                state_d = RESP;
                rd_d = 1'b0;
                wr_d = 1'b0;
                rv_d = 1'b1;
                be_err_d = waitrequest;
                data_d = waitrequest ? 32'b0 : la_out;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            {cnt_q, rt_q, wd_q, data_q, addr_q, op_q, be_q, b_q} <= '0;
            {rd_q, wr_q, rv_q, ae_q, be_err_q} <= '0;
        end else begin
            state_q <= state_d;
            {cnt_q, rt_q, wd_q, data_q, addr_q, op_q, be_q, b_q} <= {cnt_d, rt_d, wd_d, data_d, addr_d, op_d, be_d, b_d};
            {rd_q, wr_q, rv_q, ae_q, be_err_q} <= {rd_d, wr_d, rv_d, ae_d, be_err_d};
        end
    end
    assign req_ready = state_q == IDLE;
    assign resp_valid = rv_q;
    assign resp_data = data_q;
    assign addr_err = ae_q;
    assign bus_err = be_err_q;
    assign address = addr_q;
    assign read = rd_q;
    assign write = wr_q;
    assign byteenable = be_q;
    assign writedata = wd_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor of the CPU's memory address/byte-enable mux: a sequential load/store/fetch engine between the multicycle MIPS datapath and the Avalon-style memory bus.
- Accepts one request at a time (instruction fetch or data access), drives address/byteenable/writedata, and honours waitrequest with a watchdog timeout.
- Returns aligned, sign/zero-extended or LWL/LWR-merged load data.
- Flags misaligned or timed-out accesses instead of issuing bad bus cycles.

Parameters:
- ADDR_W, 32: bus address width. The internal byte address is 32 bits; the bus address is its low ADDR_W bits with [1:0] forced to 00.
- TIMEOUT_CYCLES, 0: maximum consecutive waitrequest cycles before abort. 0 disables the watchdog.
- ALIGN_CHECK, 1: 1 = LH/LHU/SH with addr[0]!=0, LW/SW with addr[1:0]!=0, or fetch with pc[1:0]!=0 raise addr_err. 0 = low bits ignored, as a word access.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  high in IDLE; request accepted when req_valid & req_ready
- req_fetch  in  1  1 = instruction fetch from pc (opcode ignored); 0 = data access at alu_addr
- pc  in  32  fetch address
- alu_addr  in  32  data byte address
- opcode  in  6  MIPS opcode: LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SW
- store_data  in  32  rt value for stores
- rt_old  in  32  current rt for LWL/LWR merge
- resp_valid  out  1  one-cycle response strobe
- resp_data  out  32  fetched word / final load result; 0 for stores and errors
- addr_err  out  1  valid with resp_valid: misaligned access
- bus_err  out  1  valid with resp_valid: watchdog timeout
- address  out  ADDR_W  bus address
- read  out  1  bus read
- write  out  1  bus write
- byteenable  out  4  bus lane enables
- writedata  out  32  bus write data
- waitrequest  in  1  bus stall
- readdata  in  32  bus read data

Behaviour:
- Reset (async, reset_n=0): state IDLE; read, write, resp_valid, addr_err and bus_err = 0; address, byteenable, writedata and resp_data = 0; watchdog counter = 0.
- Acceptance: on acceptance, req_fetch, address, opcode, store_data and rt_old are registered. Inputs are ignored outside IDLE.
- FSM states: IDLE, BUS, RESP.
- IDLE transitions:
  - accepted and misaligned (ALIGN_CHECK=1) → RESP with addr_err=1; no bus cycle.
  - accepted otherwise → BUS.
- BUS:
  - read (loads, fetch) or write (stores) held high, with address, byteenable and writedata stable, while waitrequest=1.
  - On the edge where waitrequest=0: readdata is captured and the state moves to RESP.
  - The watchdog counts waitrequest=1 cycles. On reaching TIMEOUT_CYCLES, read/write drop and the state moves to RESP with bus_err=1.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready goes high the cycle after RESP.
- Latency: zero-wait access = accept at edge 0, bus cycle in cycle 1, resp_valid in cycle 2. Each waitrequest cycle adds 1.
- Byteenable, with b = addr[1:0]:
  - fetch/LW/SW/LWL/LWR = 1111
  - LB/LBU/SB = 1<<b
  - LH/LHU/SH = 0011 if b[1]=0, else 1100
- Writedata:
  - SB = byte replicated on all four lanes.
  - SH = halfword on both halves.
  - SW = store_data.
- Load result, with r = readdata and little-endian lanes:
  - LB/LBU: lane b, sign-extended / zero-extended.
  - LH/LHU: half b[1], sign-extended / zero-extended.
  - LW / fetch: r.
  - LWL: (r << 8*(3-b)) | (rt_old & ~(FFFFFFFF << 8*(3-b))).
  - LWR: (r >> 8*b) | (rt_old & ~(FFFFFFFF >> 8*b)).
- Error responses: resp_data=0. addr_err and bus_err are never both 1.
- ALIGN_CHECK=0: misaligned LW/SW/fetch are issued as aligned word accesses; misaligned LH uses the b[1] half.
- Reset mid-BUS: read/write deassert immediately (asynchronously). No response is produced.
- Unlisted opcode with req_fetch=0: no bus cycle; RESP with addr_err=0, bus_err=0, resp_data=0.

Decomposition:
- Package mem_access_pkg:
  - opcode enum (the ten load/store opcodes)
  - FSM state enum
  - lane/shift helper function for byteenable
- Sub-module load_align: combinational extract, extend and LWL/LWR merge from (r, rt_old, opcode, b). Instantiated once in the datapath feeding the resp_data register.

Test Plan:
- Fetch pc=0x0000_0400, readdata=0x2402_0005, no wait → read in cycle 1 with byteenable=1111 and address=0x400; resp_valid in cycle 2; resp_data=0x2402_0005.
- LB at alu_addr=0x1003, readdata=0x80FF_0000 → byteenable=1000; resp_data=0xFFFF_FF80. LBU at the same address → resp_data=0x0000_0080.
- SH at 0x1002 with store_data=0x1234_ABCD and waitrequest high for 3 cycles → write held 4 cycles with byteenable=1100 and writedata=0xABCD_ABCD; resp_valid 1 cycle after release.
- LWL at 0x1001 with rt_old=0x1122_3344 and r=0xAABB_CCDD → resp_data=0xCCDD_3344. LWR at 0x1001 → resp_data=0x11AA_BBCC.
- ALIGN_CHECK=1, LW at 0x1002 → no read asserted; resp_valid in cycle 1 with addr_err=1 and resp_data=0. With TIMEOUT_CYCLES=4 and waitrequest stuck high → read drops after 4 cycles; bus_err=1.
- reset_n pulsed low during a BUS wait → read=0 in the same cycle; no resp_valid; req_ready=1 after release; the next request completes normally.
